// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: shared aspect encodings, phase codes and default dwell times
package traffic_light_pkg;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam int GREEN_CYC_DEF  = 5;
    localparam int YELLOW_CYC_DEF = 1;
    localparam int ALLRED_CYC_DEF = 1;
    typedef enum logic [2:0] {
        NSG = 3'd0,
        NSY = 3'd1,
        AR1 = 3'd2,
        EWG = 3'd3,
        EWY = 3'd4,
        AR2 = 3'd5,
        BAD = 3'd7
    } phase_e;
    typedef enum logic [1:0] {ASP_RED, ASP_YEL, ASP_GRN, ASP_INV} aspect_e;
    typedef enum logic {SYNC, TRACK} mon_state_e;
    function automatic phase_e next_phase(phase_e p);
        return p == AR2 ? NSG : phase_e'(p + 3'd1);
    endfunction
endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: traffic-light bus plus monitor result signals
//   lights                 6-bit bus, [5:3] E-W aspect, [2:0] N-S aspect
//   phase/dwell/locked     decoded phase, cycles in phase, tracking flag
//   err_*                  one-cycle violation pulses
//   err_count              saturating error counter (TL_MON_ERRCNT_EN only)
//   master: drives lights; slave: the monitor
interface traffic_light_monitor_if #(parameter int CNT_W = 4);
    logic [5:0]       lights;
    logic [2:0]       phase;
    logic [CNT_W-1:0] dwell;
    logic             locked;
    logic             err_encode;
    logic             err_conflict;
    logic             err_seq;
    logic             err_timing;
`ifdef TL_MON_ERRCNT_EN
    logic [7:0]       err_count;
`endif
    modport master (
        output lights,
        input  phase, dwell, locked, err_encode, err_conflict, err_seq, err_timing
`ifdef TL_MON_ERRCNT_EN
        , input err_count
`endif
    );
    modport slave (
        input  lights,
        output phase, dwell, locked, err_encode, err_conflict, err_seq, err_timing
`ifdef TL_MON_ERRCNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/tl_aspect_decode.sv
// tl_aspect_decode: maps one 3-bit aspect field to red/yellow/green/invalid
//   field_i   3-bit one-hot aspect field
//   aspect_o  decoded aspect
module tl_aspect_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] field_i,
    output aspect_e    aspect_o
);
    always_comb aspect_o = field_i == RED ? ASP_RED :
                           field_i == YEL ? ASP_YEL :
                           field_i == GRN ? ASP_GRN : ASP_INV;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker locking onto the six-phase light cycle
//   clk, reset  clock and synchronous active-high reset
//   bus         traffic_light_monitor_if.slave (lights in, phase/dwell/locked/err_* out)
//   Optional TL_MON_ERRCNT_EN adds a saturating 8-bit err_count on the bus.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int GREEN_CYC  = GREEN_CYC_DEF,
    parameter int YELLOW_CYC = YELLOW_CYC_DEF,
    parameter int ALLRED_CYC = ALLRED_CYC_DEF,
    parameter int CNT_W      = 4
) (
    input logic clk,
    input logic reset,
    traffic_light_monitor_if.slave bus
);
    logic [5:0]       lights_q;
    logic             vld_q;
    aspect_e          ew, ns;
    mon_state_e       state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             enc_q, enc_d, con_q, con_d, seq_q, seq_d, tim_q, tim_d;
    logic             change;
    function automatic logic [CNT_W-1:0] req(phase_e p);
        return p == NSG || p == EWG ? CNT_W'(GREEN_CYC) :
               p == NSY || p == EWY ? CNT_W'(YELLOW_CYC) : CNT_W'(ALLRED_CYC);
    endfunction
    tl_aspect_decode u_ew (.field_i(lights_q[5:3]), .aspect_o(ew));
    tl_aspect_decode u_ns (.field_i(lights_q[2:0]), .aspect_o(ns));
    always_comb begin
        enc_d   = ew == ASP_INV || ns == ASP_INV;
        con_d   = ew inside {ASP_YEL, ASP_GRN} && ns inside {ASP_YEL, ASP_GRN};
        // all-red is ambiguous on its own; the phase before it tells AR1 from AR2
        phase_d = ew == ASP_RED && ns == ASP_GRN ? NSG :
                  ew == ASP_RED && ns == ASP_YEL ? NSY :
                  ew == ASP_GRN && ns == ASP_RED ? EWG :
                  ew == ASP_YEL && ns == ASP_RED ? EWY :
                  ew == ASP_RED && ns == ASP_RED ?
                      (state_q == TRACK && (phase_q == EWY || phase_q == AR2) ? AR2 : AR1) :
                  BAD;
        change  = phase_d != phase_q;
        dwell_d = change ? CNT_W'(1) : &dwell_q ? dwell_q : dwell_q + 1'b1;
        seq_d   = state_q == TRACK && change && phase_d != next_phase(phase_q);
        // short dwell is judged at the change; overstay fires once at required+1
        tim_d   = state_q == TRACK &&
                  (change ? dwell_q < req(phase_q) : dwell_d == req(phase_q) + 1'b1);
        state_d = state_q;
        if (state_q == SYNC && change && phase_q != BAD && (phase_d == NSG || phase_d == EWG))
            state_d = TRACK;
        else if (seq_d)
            state_d = SYNC;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            lights_q <= '0;
            vld_q    <= 1'b0;
            state_q  <= SYNC;
            phase_q  <= BAD;
            dwell_q  <= '0;
            enc_q    <= 1'b0;
            con_q    <= 1'b0;
            seq_q    <= 1'b0;
            tim_q    <= 1'b0;
        end else begin
            lights_q <= bus.lights;
            vld_q    <= 1'b1;
            // the cleared lights_q after reset is not a real sample
            if (vld_q) begin
                state_q <= state_d;
                phase_q <= phase_d;
                dwell_q <= dwell_d;
                enc_q   <= enc_d;
                con_q   <= con_d;
                seq_q   <= seq_d;
                tim_q   <= tim_d;
            end
        end
    end
    assign bus.phase        = phase_q;
    assign bus.dwell        = dwell_q;
    assign bus.locked       = state_q == TRACK;
    assign bus.err_encode   = enc_q;
    assign bus.err_conflict = con_q;
    assign bus.err_seq      = seq_q;
    assign bus.err_timing   = tim_q;
`ifdef TL_MON_ERRCNT_EN
    logic [7:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (vld_q && (enc_d || con_d || seq_d || tim_d) && cnt_q != 8'hff)
            cnt_q <= cnt_q + 8'd1;
    end
    assign bus.err_count = cnt_q;
`endif
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed stimulus with a queued scoreboard for traffic_light_monitor
module tb_traffic_light_monitor;
  localparam logic [5:0] L_NSG = 6'b100001;
  localparam logic [5:0] L_NSY = 6'b100010;
  localparam logic [5:0] L_AR  = 6'b100100;
  localparam logic [5:0] L_EWG = 6'b001100;
  localparam logic [5:0] L_EWY = 6'b010100;
  localparam logic [5:0] L_CON = 6'b001001;
  localparam logic [5:0] L_ENC = 6'b110001;
  typedef struct {
    int         due;
    logic [2:0] ph;
    logic [3:0] dw;
    logic       lk;
    logic       lk_chk;
    logic [3:0] err;
    logic [7:0] cnt;
    logic       cnt_chk;
    string      name;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;
  logic [3:0] got_err;
  logic       bad;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  traffic_light_monitor_if #(.CNT_W(4)) bus ();
  traffic_light_monitor dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic expect_at(input int off, input logic [2:0] ph, input logic [3:0] dw,
                           input logic lk, input logic lkc, input logic [3:0] er,
                           input logic [7:0] cnt, input logic cc, input string nm);
    exp_t x;
    x.due = cyc + off; x.ph = ph; x.dw = dw; x.lk = lk; x.lk_chk = lkc;
    x.err = er; x.cnt = cnt; x.cnt_chk = cc; x.name = nm;
    q.push_back(x);
  endtask
  task automatic drv(input logic [5:0] l, input logic [2:0] ph, input logic [3:0] dw,
                     input logic lk, input logic lkc, input logic [3:0] er, input string nm);
    bus.lights = l;
    expect_at(2, ph, dw, lk, lkc, er, 8'd0, 1'b0, nm);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      got_err = {bus.err_encode, bus.err_conflict, bus.err_seq, bus.err_timing};
      bad = e.due != cyc || bus.phase !== e.ph || bus.dwell !== e.dw ||
            (e.lk_chk && bus.locked !== e.lk) || got_err !== e.err;
`ifdef TL_MON_ERRCNT_EN
      bad = bad || (e.cnt_chk && bus.err_count !== e.cnt);
`endif
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s @%0d: got phase=%0d dwell=%0d locked=%b err(enc,con,seq,tim)=%b, expected phase=%0d dwell=%0d locked=%b err=%b",
                 e.name, cyc, bus.phase, bus.dwell, bus.locked, got_err, e.ph, e.dw, e.lk, e.err);
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.lights = '0;
    expect_at(1, 3'd7, 4'd0, 1'b0, 1'b1, 4'b0000, 8'd0, 1'b1, "reset");
    repeat (2) @(negedge clk);
    checks++;
    if (bus.phase !== 3'd7 || bus.dwell !== 4'd0 || bus.locked !== 1'b0 ||
        {bus.err_encode, bus.err_conflict, bus.err_seq, bus.err_timing} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: phase=%0d dwell=%0d locked=%b err=%b", bus.phase, bus.dwell,
               bus.locked, {bus.err_encode, bus.err_conflict, bus.err_seq, bus.err_timing});
    end
    reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) drv(L_NSG, 3'd0, 4'(i + 1), p > 0, 1'b1, 4'b0, "legal_nsg");
      drv(L_NSY, 3'd1, 4'd1, p > 0, 1'b1, 4'b0, "legal_nsy");
      drv(L_AR,  3'd2, 4'd1, p > 0, 1'b1, 4'b0, "legal_ar1");
      for (int i = 0; i < 5; i++) drv(L_EWG, 3'd3, 4'(i + 1), 1'b1, 1'b1, 4'b0, "legal_ewg");
      drv(L_EWY, 3'd4, 4'd1, 1'b1, 1'b1, 4'b0, "legal_ewy");
      drv(L_AR,  3'd5, 4'd1, 1'b1, 1'b1, 4'b0, "legal_ar2");
    end
    for (int i = 0; i < 5; i++) drv(L_NSG, 3'd0, 4'(i + 1), 1'b1, 1'b1, 4'b0, "hold_nsg");
    drv(L_NSG, 3'd0, 4'd6, 1'b1, 1'b1, 4'b0001, "overstay");
    drv(L_NSY, 3'd1, 4'd1, 1'b1, 1'b1, 4'b0000, "nsy_after_overstay");
    drv(L_AR,  3'd2, 4'd1, 1'b1, 1'b1, 4'b0000, "ar1_after_overstay");
    for (int i = 0; i < 5; i++) drv(L_EWG, 3'd3, 4'(i + 1), 1'b1, 1'b1, 4'b0, "ewg_pre_conflict");
    drv(L_CON, 3'd7, 4'd1, 1'b0, 1'b0, 4'b0110, "conflict");
    drv(L_EWY, 3'd4, 4'd1, 1'b0, 1'b1, 4'b0000, "unlocked_after_conflict");
    drv(L_AR,  3'd2, 4'd1, 1'b0, 1'b1, 4'b0000, "unlocked_allred_ar1");
    drv(L_NSG, 3'd0, 4'd1, 1'b1, 1'b1, 4'b0000, "relock_nsg");
    for (int i = 1; i < 5; i++) drv(L_NSG, 3'd0, 4'(i + 1), 1'b1, 1'b1, 4'b0, "nsg_pre_skip");
    drv(L_AR,  3'd2, 4'd1, 1'b0, 1'b0, 4'b0010, "skip_yellow");
    drv(L_AR,  3'd2, 4'd2, 1'b0, 1'b1, 4'b0000, "unlocked_after_skip");
    drv(L_ENC, 3'd7, 4'd1, 1'b0, 1'b1, 4'b1000, "encode");
    drv(L_NSG, 3'd0, 4'd1, 1'b0, 1'b1, 4'b0000, "no_lock_from_bad");
    drv(L_NSY, 3'd1, 4'd1, 1'b0, 1'b1, 4'b0000, "sync_nsy");
    drv(L_AR,  3'd2, 4'd1, 1'b0, 1'b1, 4'b0000, "sync_ar1");
    for (int i = 0; i < 3; i++) drv(L_EWG, 3'd3, 4'(i + 1), 1'b1, 1'b1, 4'b0, "lock_ewg");
    @(negedge clk);
    reset = 1'b1;
    expect_at(1, 3'd7, 4'd0, 1'b0, 1'b1, 4'b0000, 8'd0, 1'b1, "reset_mid_ewg");
    @(negedge clk);
    reset = 1'b0;
    expect_at(1, 3'd7, 4'd0, 1'b0, 1'b1, 4'b0000, 8'd0, 1'b1, "reset_release");
    @(negedge clk);
`ifdef TL_MON_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      bus.lights = L_CON;
      @(negedge clk);
    end
    expect_at(2, 3'd7, 4'd15, 1'b0, 1'b1, 4'b0100, 8'd255, 1'b1, "errcnt_sat");
    @(negedge clk);
`endif
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL expired_wait: %0d expectation(s) never checked, first %s due @%0d",
               q.size(), q[0].name, q[0].due);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
